// File: rtl/bram_sdp_be_if.sv
// rtl/bram_sdp_be_if.sv - write/read port bundle for the byte-enabled simple-dual-port RAM
interface bram_sdp_be_if #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 8
);
    localparam int AW = $clog2(DEPTH);

    logic               we;
    logic [WIDTH/8-1:0] wr_be;
    logic [AW-1:0]      wr_add;
    logic [WIDTH-1:0]   wr_data;
    logic               rd_en;
    logic [AW-1:0]      rd_add;
    logic [WIDTH-1:0]   rd_data;
    logic               rd_valid;
    logic               busy;

    modport master (
        output we, wr_be, wr_add, wr_data, rd_en, rd_add,
        input  rd_data, rd_valid, busy
    );

    modport slave (
        input  we, wr_be, wr_add, wr_data, rd_en, rd_add,
        output rd_data, rd_valid, busy
    );
endinterface

// File: rtl/bram_sdp_be.sv
// rtl/bram_sdp_be.sv - simple-dual-port block RAM with byte enables, 1/2-cycle read latency and zero-fill sweep
module bram_sdp_be #(
    parameter int WIDTH          = 32,
    parameter int DEPTH          = 8,
    parameter int RD_LATENCY     = 1,
    parameter int RDW_MODE       = 0,
    parameter int CLEAR_ON_RESET = 1
) (
    input  logic         clk,
    input  logic         rst,
    bram_sdp_be_if.slave bus
);
    localparam int AW = $clog2(DEPTH);
    localparam int NB = WIDTH / 8;

    typedef enum logic {ST_CLEAR, ST_READY} state_t;

    state_t           state;
    logic [AW-1:0]    clr_cnt;
    logic [WIDTH-1:0] mem [DEPTH];

    logic             busy;
    logic             wr_acc;
    logic             rd_acc;
    logic [WIDTH-1:0] rd_word;
    logic [WIDTH-1:0] s1_data;
    logic             s1_valid;

    assign busy     = rst | (state == ST_CLEAR);
    assign bus.busy = busy;
    assign wr_acc   = bus.we & ~busy;
    assign rd_acc   = bus.rd_en & ~busy;

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= (CLEAR_ON_RESET != 0) ? ST_CLEAR : ST_READY;
            clr_cnt <= '0;
        end else if (state == ST_CLEAR) begin
            clr_cnt <= clr_cnt + 1'b1;
            if (clr_cnt == AW'(DEPTH - 1))
                state <= ST_READY;
        end
    end

    // Array has no reset; the sweep is the only way contents get zeroed.
    always_ff @(posedge clk) begin
        if (!rst && state == ST_CLEAR) begin
            mem[clr_cnt] <= '0;
        end else if (wr_acc) begin
            for (int i = 0; i < NB; i++)
                if (bus.wr_be[i])
                    mem[bus.wr_add][8*i +: 8] <= bus.wr_data[8*i +: 8];
        end
    end

    // In new-data mode, enabled lanes of a same-address write bypass the array.
    always_comb begin
        rd_word = mem[bus.rd_add];
        if (RDW_MODE != 0 && wr_acc && bus.wr_add == bus.rd_add) begin
            for (int i = 0; i < NB; i++)
                if (bus.wr_be[i])
                    rd_word[8*i +: 8] = bus.wr_data[8*i +: 8];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            s1_valid <= 1'b0;
            s1_data  <= '0;
        end else begin
            s1_valid <= rd_acc;
            if (rd_acc)
                s1_data <= rd_word;
        end
    end

    generate
        if (RD_LATENCY == 2) begin : g_lat2
            logic [WIDTH-1:0] s2_data;
            logic             s2_valid;

            always_ff @(posedge clk) begin
                if (rst) begin
                    s2_valid <= 1'b0;
                    s2_data  <= '0;
                end else begin
                    s2_valid <= s1_valid;
                    if (s1_valid)
                        s2_data <= s1_data;
                end
            end

            assign bus.rd_data  = s2_data;
            assign bus.rd_valid = s2_valid;
        end else begin : g_lat1
            assign bus.rd_data  = s1_data;
            assign bus.rd_valid = s1_valid;
        end
    endgenerate
endmodule

// File: tb/tb_bram_sdp_be.sv
// tb/tb_bram_sdp_be.sv - directed bench: dut_a (lat 1, old-data, clear) beside dut_b (lat 2, new-data, no clear)
module tb_bram_sdp_be;
    logic        clk = 1'b0;
    logic        rst;
    logic        we;
    logic [3:0]  wr_be;
    logic [2:0]  wr_add;
    logic [31:0] wr_data;
    logic        rd_en;
    logic [2:0]  rd_add;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    bram_sdp_be_if #(.WIDTH(32), .DEPTH(8)) bus_a ();
    bram_sdp_be_if #(.WIDTH(32), .DEPTH(8)) bus_b ();

    assign bus_a.we = we;     assign bus_b.we = we;
    assign bus_a.wr_be = wr_be;   assign bus_b.wr_be = wr_be;
    assign bus_a.wr_add = wr_add; assign bus_b.wr_add = wr_add;
    assign bus_a.wr_data = wr_data; assign bus_b.wr_data = wr_data;
    assign bus_a.rd_en = rd_en;   assign bus_b.rd_en = rd_en;
    assign bus_a.rd_add = rd_add; assign bus_b.rd_add = rd_add;

    bram_sdp_be #(.WIDTH(32), .DEPTH(8), .RD_LATENCY(1), .RDW_MODE(0), .CLEAR_ON_RESET(1))
        dut_a (.clk(clk), .rst(rst), .bus(bus_a.slave));
    bram_sdp_be #(.WIDTH(32), .DEPTH(8), .RD_LATENCY(2), .RDW_MODE(1), .CLEAR_ON_RESET(0))
        dut_b (.clk(clk), .rst(rst), .bus(bus_b.slave));

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        we = 1'b0; wr_be = 4'h0; wr_add = '0; wr_data = '0; rd_en = 1'b0; rd_add = '0;
    endtask

    task automatic wr(input logic [2:0] a, input logic [31:0] d, input logic [3:0] be);
        we = 1'b1; wr_add = a; wr_data = d; wr_be = be;
        tick();
        we = 1'b0; wr_be = 4'h0;
    endtask

    task automatic count_busy(output int n);
        n = 0;
        while (bus_a.busy === 1'b1 && n < 40) begin
            tick();
            n++;
        end
    endtask

    task automatic test_reset();
        int n;
        idle();
        rst = 1'b1;
        tick(); tick();
        n_cmp++; if (bus_a.rd_data !== 32'h0) begin n_bad++; $display("FAIL reset_rd_data: got %h want %h", bus_a.rd_data, 32'h0); end
        n_cmp++; if (bus_a.rd_valid !== 1'b0) begin n_bad++; $display("FAIL reset_rd_valid: got %b want 0", bus_a.rd_valid); end
        n_cmp++; if (bus_a.busy !== 1'b1) begin n_bad++; $display("FAIL reset_busy_a: got %b want 1", bus_a.busy); end
        n_cmp++; if (bus_b.busy !== 1'b1) begin n_bad++; $display("FAIL reset_busy_b: got %b want 1", bus_b.busy); end
        rst = 1'b0;
        #1;
        n_cmp++; if (bus_b.busy !== 1'b0) begin n_bad++; $display("FAIL noclear_busy_b: got %b want 0", bus_b.busy); end
        count_busy(n);
        n_cmp++; if (n != 8) begin n_bad++; $display("FAIL clear_edges_first: got %0d want 8", n); end
    endtask

    task automatic test_clear();
        int n;
        for (int k = 0; k < 8; k++) wr(3'(k), 32'hC0DE_0000 + k, 4'hF);
        rd_en = 1'b1; rd_add = 3'd4;
        tick();
        rd_en = 1'b0;
        n_cmp++; if (bus_a.rd_data !== 32'hC0DE_0004) begin n_bad++; $display("FAIL preload_rd: got %h want %h", bus_a.rd_data, 32'hC0DE_0004); end
        rst = 1'b1;
        tick(); tick();
        rst = 1'b0;
        count_busy(n);
        n_cmp++; if (n != 8) begin n_bad++; $display("FAIL clear_edges: got %0d want 8", n); end
        for (int k = 0; k < 8; k++) begin
            rd_en = 1'b1; rd_add = 3'(k);
            tick();
            n_cmp++; if (bus_a.rd_valid !== 1'b1) begin n_bad++; $display("FAIL clear_valid[%0d]: got %b want 1", k, bus_a.rd_valid); end
            n_cmp++; if (bus_a.rd_data !== 32'h0) begin n_bad++; $display("FAIL clear_data[%0d]: got %h want 0", k, bus_a.rd_data); end
        end
        rd_en = 1'b0;
        tick();
        n_cmp++; if (bus_a.rd_valid !== 1'b0) begin n_bad++; $display("FAIL clear_valid_end: got %b want 0", bus_a.rd_valid); end
    endtask

    task automatic test_byte_enables();
        wr(3'd3, 32'hAABB_CCDD, 4'b1111);
        wr(3'd3, 32'h1122_3344, 4'b0101);
        rd_en = 1'b1; rd_add = 3'd3;
        tick();
        rd_en = 1'b0;
        n_cmp++; if (bus_a.rd_data !== 32'hAA22_CC44) begin n_bad++; $display("FAIL be_merge_a: got %h want %h", bus_a.rd_data, 32'hAA22_CC44); end
        tick();
        n_cmp++; if (bus_b.rd_data !== 32'hAA22_CC44) begin n_bad++; $display("FAIL be_merge_b: got %h want %h", bus_b.rd_data, 32'hAA22_CC44); end
        wr(3'd3, 32'h0000_0000, 4'b0000);
        rd_en = 1'b1; rd_add = 3'd3;
        tick();
        rd_en = 1'b0;
        n_cmp++; if (bus_a.rd_data !== 32'hAA22_CC44) begin n_bad++; $display("FAIL be_zero_a: got %h want %h", bus_a.rd_data, 32'hAA22_CC44); end
    endtask

    task automatic test_rdw();
        wr(3'd5, 32'h1234_5678, 4'hF);
        tick();
        we = 1'b1; wr_be = 4'b0011; wr_add = 3'd5; wr_data = 32'hFFFF_FFFF;
        rd_en = 1'b1; rd_add = 3'd5;
        tick();
        we = 1'b0; wr_be = 4'h0;
        n_cmp++; if (bus_a.rd_data !== 32'h1234_5678) begin n_bad++; $display("FAIL rdw_old_a: got %h want %h", bus_a.rd_data, 32'h1234_5678); end
        tick();
        rd_en = 1'b0;
        n_cmp++; if (bus_b.rd_data !== 32'h1234_FFFF) begin n_bad++; $display("FAIL rdw_new_b: got %h want %h", bus_b.rd_data, 32'h1234_FFFF); end
        n_cmp++; if (bus_a.rd_data !== 32'h1234_FFFF) begin n_bad++; $display("FAIL rdw_next_a: got %h want %h", bus_a.rd_data, 32'h1234_FFFF); end
        tick();
        n_cmp++; if (bus_b.rd_data !== 32'h1234_FFFF || bus_b.rd_valid !== 1'b1) begin n_bad++; $display("FAIL rdw_next_b: got %h/%b want %h/1", bus_b.rd_data, bus_b.rd_valid, 32'h1234_FFFF); end
    endtask

    task automatic test_latency();
        for (int k = 0; k < 3; k++) wr(3'(k), 32'h100 + k, 4'hF);
        for (int t = 1; t <= 5; t++) begin
            rd_en = (t <= 3); rd_add = 3'((t - 1) % 8);
            tick();
            n_cmp++; if (bus_a.rd_valid !== (t <= 3)) begin n_bad++; $display("FAIL lat1_valid[t%0d]: got %b want %b", t, bus_a.rd_valid, (t <= 3)); end
            if (t <= 3) begin
                n_cmp++; if (bus_a.rd_data !== 32'h100 + t - 1) begin n_bad++; $display("FAIL lat1_data[t%0d]: got %h want %h", t, bus_a.rd_data, 32'h100 + t - 1); end
            end
            n_cmp++; if (bus_b.rd_valid !== (t >= 2 && t <= 4)) begin n_bad++; $display("FAIL lat2_valid[t%0d]: got %b want %b", t, bus_b.rd_valid, (t >= 2 && t <= 4)); end
            if (t >= 2 && t <= 4) begin
                n_cmp++; if (bus_b.rd_data !== 32'h100 + t - 2) begin n_bad++; $display("FAIL lat2_data[t%0d]: got %h want %h", t, bus_b.rd_data, 32'h100 + t - 2); end
            end
        end
    endtask

    task automatic test_busy_gating();
        int n = 0;
        rst = 1'b1;
        tick();
        rst = 1'b0;
        we = 1'b1; wr_be = 4'hF; wr_data = 32'hDEAD_BEEF; rd_en = 1'b1;
        while (bus_a.busy === 1'b1 && n < 40) begin
            wr_add = 3'(n % 8); rd_add = 3'(n % 8);
            tick();
            n++;
            n_cmp++; if (bus_a.rd_valid !== 1'b0) begin n_bad++; $display("FAIL gate_valid[%0d]: got %b want 0", n, bus_a.rd_valid); end
        end
        idle();
        n_cmp++; if (n != 8) begin n_bad++; $display("FAIL gate_edges: got %0d want 8", n); end
        for (int k = 0; k < 8; k++) begin
            rd_en = 1'b1; rd_add = 3'(k);
            tick();
            n_cmp++; if (bus_a.rd_data !== 32'h0 || bus_a.rd_valid !== 1'b1) begin n_bad++; $display("FAIL gate_data[%0d]: got %h/%b want 0/1", k, bus_a.rd_data, bus_a.rd_valid); end
        end
        rd_en = 1'b0;
        tick();
    endtask

    task automatic test_reset_mid();
        int n;
        rst = 1'b1;
        tick();
        rst = 1'b0;
        for (int k = 0; k < 4; k++) tick();
        n_cmp++; if (bus_a.busy !== 1'b1) begin n_bad++; $display("FAIL mid_busy: got %b want 1", bus_a.busy); end
        rst = 1'b1;
        tick();
        rst = 1'b0;
        count_busy(n);
        n_cmp++; if (n != 8) begin n_bad++; $display("FAIL mid_restart_edges: got %0d want 8", n); end
        wr(3'd2, 32'h0000_0055, 4'hF);
        rd_en = 1'b1; rd_add = 3'd2;
        tick();
        rd_en = 1'b0; rst = 1'b1;
        tick();
        n_cmp++; if (bus_b.rd_valid !== 1'b0 || bus_b.rd_data !== 32'h0) begin n_bad++; $display("FAIL flush_b: got %h/%b want 0/0", bus_b.rd_data, bus_b.rd_valid); end
        n_cmp++; if (bus_a.rd_valid !== 1'b0 || bus_a.rd_data !== 32'h0) begin n_bad++; $display("FAIL flush_a: got %h/%b want 0/0", bus_a.rd_data, bus_a.rd_valid); end
        rst = 1'b0;
        n = 0;
        while (bus_a.busy === 1'b1 && n < 40) begin
            tick();
            n++;
            n_cmp++; if (bus_b.rd_valid !== 1'b0) begin n_bad++; $display("FAIL flush_late_b[%0d]: got %b want 0", n, bus_b.rd_valid); end
        end
        n_cmp++; if (n != 8) begin n_bad++; $display("FAIL flush_restart_edges: got %0d want 8", n); end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_clear();
        test_byte_enables();
        test_rdw();
        test_latency();
        test_busy_gating();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
